// File: rtl/pipe_skid_buf.sv
// Chained ready/valid pipeline buffer: DEPTH stages, each with a main register and an optional skid
// register, plus global stall and flush. Stage DEPTH-1 is the head that drives the outputs.
module pipe_skid_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1,
    parameter int SKID   = 1,
    parameter int CNT_W  = $clog2(2*DEPTH+1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              ready_i,
    output logic [CNT_W-1:0]  count_o
);

    logic [DEPTH-1:0]  m_valid;
    logic [DEPTH-1:0]  s_valid;
    logic [DATA_W-1:0] m_data [DEPTH];
    logic [DATA_W-1:0] s_data [DEPTH];

    // stage_ready[DEPTH] is the downstream consumer; chain_* is what each stage sees from upstream
    logic [DEPTH:0]    stage_ready;
    logic [DEPTH-1:0]  chain_valid;
    logic [DATA_W-1:0] chain_data [DEPTH];
    logic [DEPTH-1:0]  in_xfer;
    logic [DEPTH-1:0]  out_xfer;

    always_comb begin
        stage_ready        = '0;
        stage_ready[DEPTH] = ready_i;
        // With a skid register, ready depends only on local state, cutting the ready path per stage
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (SKID != 0) begin
                stage_ready[i] = ~s_valid[i];
            end else begin
                stage_ready[i] = ~m_valid[i] | stage_ready[i+1];
            end
        end
    end

    always_comb begin
        chain_valid    = '0;
        chain_valid[0] = valid_i;
        for (int i = 0; i < DEPTH; i++) begin
            chain_data[i] = data_i;
        end
        for (int i = 1; i < DEPTH; i++) begin
            chain_valid[i] = m_valid[i-1];
            chain_data[i]  = m_data[i-1];
        end
    end

    always_comb begin
        in_xfer  = '0;
        out_xfer = '0;
        for (int i = 0; i < DEPTH; i++) begin
            in_xfer[i]  = chain_valid[i] & stage_ready[i] & ~stall_i;
            out_xfer[i] = m_valid[i] & stage_ready[i+1] & ~stall_i;
        end
    end

    // Flush clears only the valid bits; data registers keep their stale contents
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_valid <= '0;
            s_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                m_data[i] <= '0;
                s_data[i] <= '0;
            end
        end else if (flush_i) begin
            m_valid <= '0;
            s_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (out_xfer[i]) begin
                    if (s_valid[i]) begin
                        m_data[i]  <= s_data[i];
                        s_valid[i] <= 1'b0;
                    end else if (in_xfer[i]) begin
                        m_data[i] <= chain_data[i];
                    end else begin
                        m_valid[i] <= 1'b0;
                    end
                end else if (in_xfer[i]) begin
                    if (m_valid[i] && (SKID != 0)) begin
                        s_data[i]  <= chain_data[i];
                        s_valid[i] <= 1'b1;
                    end else begin
                        m_data[i]  <= chain_data[i];
                        m_valid[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        count_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_o = count_o + CNT_W'(m_valid[i]) + CNT_W'(s_valid[i]);
        end
    end

    assign ready_o = stage_ready[0];
    assign valid_o = m_valid[DEPTH-1];
    assign data_o  = m_data[DEPTH-1];

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Scoreboard bench for pipe_skid_buf: three configurations share stimulus, one is observed at a time.
module tb_pipe_skid_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, valid_in, ready_in;
    logic [15:0] data_in;

    logic        rdy0, vld0, rdy1, vld1, rdy2, vld2;
    logic [15:0] dat0, dat1, dat2;
    logic [2:0]  cnt0, cnt1;
    logic [1:0]  cnt2;

    int          sel = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          emitted = 0;
    logic [31:0] sb [$];
    logic [31:0] cur_ready, cur_valid, cur_data, cur_count;

    always #5 clk = ~clk;

    pipe_skid_buf #(.DATA_W(16), .DEPTH(3), .SKID(1)) dut_d3 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(valid_in),
        .data_i(data_in), .ready_o(rdy0), .valid_o(vld0), .data_o(dat0), .ready_i(ready_in),
        .count_o(cnt0));

    pipe_skid_buf #(.DATA_W(16), .DEPTH(2), .SKID(1)) dut_d2 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(valid_in),
        .data_i(data_in), .ready_o(rdy1), .valid_o(vld1), .data_o(dat1), .ready_i(ready_in),
        .count_o(cnt1));

    pipe_skid_buf #(.DATA_W(16), .DEPTH(1), .SKID(0)) dut_d1 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(valid_in),
        .data_i(data_in), .ready_o(rdy2), .valid_o(vld2), .data_o(dat2), .ready_i(ready_in),
        .count_o(cnt2));

    always_comb begin
        cur_ready = 32'(rdy0);
        cur_valid = 32'(vld0);
        cur_data  = 32'(dat0);
        cur_count = 32'(cnt0);
        case (sel)
            1: begin
                cur_ready = 32'(rdy1);
                cur_valid = 32'(vld1);
                cur_data  = 32'(dat1);
                cur_count = 32'(cnt1);
            end
            2: begin
                cur_ready = 32'(rdy2);
                cur_valid = 32'(vld2);
                cur_data  = 32'(dat2);
                cur_count = 32'(cnt2);
            end
            default: ;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic r,
                                 input logic s, input logic f);
        valid_in = v;
        data_in  = d;
        ready_in = r;
        stall    = s;
        flush    = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        rst = 1'b0;
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        tick();
        emitted = 0;
    endtask

    task automatic drain(input int max_cycles);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < max_cycles; i++) begin
            if (sb.size() == 0 && !cur_valid[0]) break;
            tick();
        end
        checkOutput("drain_sb_empty", 32'(sb.size()), 32'd0);
        checkOutput("drain_valid", cur_valid, 32'd0);
    endtask

    // Handshakes are sampled mid-cycle, ahead of the edge that commits them
    always @(negedge clk) begin
        if (!rst || flush) begin
            sb.delete();
        end else if (!stall) begin
            if (cur_valid[0] && ready_in) begin
                if (sb.size() == 0) begin
                    checkOutput("emit_with_empty_sb", 32'd0, 32'd1);
                end else begin
                    checkOutput("emit_data", cur_data, sb.pop_front());
                    emitted++;
                end
            end
            if (valid_in && cur_ready[0]) sb.push_back(32'(data_in));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          accepts;
        int          idx;
        int          d;
        logic        acc;
        logic        st;
        logic        r;

        sel = 0;
        resetDut();
        checkOutput("rst_valid", cur_valid, 32'd0);
        checkOutput("rst_data", cur_data, 32'd0);
        checkOutput("rst_count", cur_count, 32'd0);
        checkOutput("rst_ready", cur_ready, 32'd1);
        checkOutput("rst_ready_d2", 32'(rdy1), 32'd1);
        checkOutput("rst_ready_d1s0", 32'(rdy2), 32'd1);

        // DEPTH=3 back-to-back stream
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 16'(k), 1'b1, 1'b0, 1'b0);
            tick();
            checkOutput("t1_valid", cur_valid, (k >= 3) ? 32'd1 : 32'd0);
            checkOutput("t1_count", cur_count, (k >= 3) ? 32'd3 : 32'(k));
            if (k >= 3) checkOutput("t1_data", cur_data, 32'(k - 2));
        end
        drain(12);
        checkOutput("t1_emitted", 32'(emitted), 32'd8);

        // DEPTH=2 fill to capacity under backpressure
        sel = 1;
        resetDut();
        accepts = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 16'(16 + accepts + 1), 1'b0, 1'b0, 1'b0);
            if (!cur_ready[0]) break;
            accepts++;
            tick();
        end
        checkOutput("t2_accepts", 32'(accepts), 32'd4);
        checkOutput("t2_count_full", cur_count, 32'd4);
        checkOutput("t2_ready_full", cur_ready, 32'd0);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        tick();
        // Stage 0 skid only drains on the following edge, once the head has room again
        checkOutput("t2_ready_after_emit1", cur_ready, 32'd0);
        checkOutput("t2_count_after_emit1", cur_count, 32'd3);
        tick();
        checkOutput("t2_ready_after_emit2", cur_ready, 32'd1);
        drain(8);
        checkOutput("t2_emitted", 32'(emitted), 32'd4);

        // Stall held for three cycles mid-stream
        sel = 0;
        resetDut();
        idx = 0;
        for (int c = 0; c < 30; c++) begin
            st = (c >= 4 && c < 7);
            if (idx < 10) applyStimulus(1'b1, 16'(33 + idx), 1'b1, st, 1'b0);
            else          applyStimulus(1'b0, 16'h0, 1'b1, st, 1'b0);
            acc = (idx < 10) && cur_ready[0] && !st;
            tick();
            if (acc) idx++;
            checkOutput("t3_count", cur_count, 32'(sb.size()));
            if (st) begin
                checkOutput("t3_stall_valid", cur_valid, 32'(sb.size() != 0));
                if (sb.size() != 0) checkOutput("t3_stall_data", cur_data, sb[0]);
            end
        end
        drain(8);
        checkOutput("t3_emitted", 32'(emitted), 32'd10);

        // Flush with an offered item in the same cycle
        resetDut();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 16'(64 + k), 1'b0, 1'b0, 1'b0);
            tick();
        end
        checkOutput("t4_count_pre", cur_count, 32'd3);
        checkOutput("t4_ready_pre", cur_ready, 32'd1);
        applyStimulus(1'b1, 16'h00EE, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("t4_count_post", cur_count, 32'd0);
        checkOutput("t4_valid_post", cur_valid, 32'd0);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        repeat (5) tick();
        checkOutput("t4_valid_late", cur_valid, 32'd0);
        checkOutput("t4_emitted", 32'(emitted), 32'd0);

        // Asynchronous reset between edges
        resetDut();
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 16'(113 + k), 1'b0, 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        checkOutput("t5_count_pre", cur_count, 32'd2);
        checkOutput("t5_valid_pre", cur_valid, 32'd1);
        checkOutput("t5_data_pre", cur_data, 32'd113);
        #2 rst = 1'b0;
        #1;
        checkOutput("t5_valid_rst", cur_valid, 32'd0);
        checkOutput("t5_data_rst", cur_data, 32'd0);
        checkOutput("t5_count_rst", cur_count, 32'd0);
        checkOutput("t5_ready_rst", cur_ready, 32'd1);
        #4 rst = 1'b1;
        tick();
        applyStimulus(1'b1, 16'h0055, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("t5_valid_lat1", cur_valid, 32'd0);
        tick();
        checkOutput("t5_valid_lat2", cur_valid, 32'd0);
        tick();
        checkOutput("t5_valid_lat3", cur_valid, 32'd1);
        checkOutput("t5_data_lat3", cur_data, 32'h55);
        drain(6);
        checkOutput("t5_emitted", 32'(emitted), 32'd1);

        // SKID=0, DEPTH=1 with ready_i toggling
        sel = 2;
        resetDut();
        d = 1;
        for (int c = 0; c < 8; c++) begin
            r = (c % 2 == 0);
            applyStimulus(1'b1, 16'(d), r, 1'b0, 1'b0);
            #1;
            checkOutput("t6_ready", cur_ready, 32'((sb.size() == 0) || r));
            checkOutput("t6_valid", cur_valid, 32'(sb.size() != 0));
            acc = cur_ready[0];
            tick();
            if (acc) d++;
        end
        checkOutput("t6_accepts", 32'(d - 1), 32'd4);
        drain(6);
        checkOutput("t6_emitted", 32'(emitted), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
